// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: a pipeline WB requester (A) and a multi-cycle unit (B) share
// one registered write port; B gains priority after STARVE_LIMIT consecutive denied cycles.
module rf_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [4:0]       a_rd,
    input  logic [31:0]      a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [4:0]       b_rd,
    input  logic [31:0]      b_data,
    output logic             b_ready,
    output logic             RegWrite,
    output logic [4:0]       write_reg,
    output logic [31:0]      write_data,
    output logic             b_prio,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [0:0] {
        StPrioA,
        StPrioB
    } state_e;

    localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

    state_e           state_q, state_d;
    logic [3:0]       starve_q, starve_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       write_reg_q, write_reg_d;
    logic [31:0]      write_data_q, write_data_d;

    logic        a_grant;
    logic        b_grant;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    // Grants are suppressed while reset is asserted so nothing is consumed during reset.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (rst_n) begin
            if (a_valid && b_valid) begin
                a_grant = (state_q == StPrioA);
                b_grant = (state_q == StPrioB);
            end else begin
                a_grant = a_valid;
                b_grant = b_valid;
            end
        end
    end

    assign a_ready = a_grant;
    assign b_ready = b_grant;

    always_comb begin
        starve_d = starve_q;
        if (!b_valid || b_grant) begin
            starve_d = 4'd0;
        end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StPrioA: begin
                if (starve_d == StarveLimit) begin
                    state_d = StPrioB;
                end
            end
            StPrioB: begin
                // Priority is one-shot: drop it once B is served or withdraws.
                if (b_grant || !b_valid) begin
                    state_d = StPrioA;
                end
            end
            default: state_d = StPrioA;
        endcase
    end

    always_comb begin
        sel_rd   = a_grant ? a_rd : b_rd;
        sel_data = a_grant ? a_data : b_data;
    end

    // Writes to x0 are consumed but zero the port instead of holding the previous address.
    always_comb begin
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (a_grant || b_grant) begin
            if (sel_rd != 5'd0) begin
                reg_write_d  = 1'b1;
                write_reg_d  = sel_rd;
                write_data_d = sel_data;
            end else begin
                write_reg_d  = 5'd0;
                write_data_d = 32'd0;
            end
        end
    end

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (a_valid && b_valid && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StPrioA;
            starve_q       <= 4'd0;
            conflict_cnt_q <= '0;
            reg_write_q    <= 1'b0;
            write_reg_q    <= 5'd0;
            write_data_q   <= 32'd0;
        end else begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            conflict_cnt_q <= conflict_cnt_d;
            reg_write_q    <= reg_write_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
        end
    end

    assign RegWrite     = reg_write_q;
    assign write_reg    = write_reg_q;
    assign write_data   = write_data_q;
    assign b_prio       = (state_q == StPrioB);
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter, checked against a cycle-level behavioural
// model; a second instance with a 4-bit conflict counter exercises saturation.
module tb_rf_write_arbiter;

    localparam int StarveLimit = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, RegWrite, b_prio;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [15:0] conflict_cnt;
    logic        s_a_ready, s_b_ready, s_reg_write, s_b_prio;
    logic [4:0]  s_write_reg;
    logic [31:0] s_write_data;
    logic [3:0]  s_conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    bit          m_prio_b;
    int          m_starve, m_conf, m_conf4;
    bit          m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    rf_write_arbiter #(.STARVE_LIMIT(StarveLimit), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .b_prio(b_prio), .conflict_cnt(conflict_cnt)
    );

    rf_write_arbiter #(.STARVE_LIMIT(StarveLimit), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(s_a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(s_b_ready),
        .RegWrite(s_reg_write), .write_reg(s_write_reg), .write_data(s_write_data),
        .b_prio(s_b_prio), .conflict_cnt(s_conflict_cnt)
    );

    task automatic model_ready(output bit ar, output bit br);
        ar = 1'b0;
        br = 1'b0;
        if (rst_n === 1'b1) begin
            if (a_valid === 1'b1 && b_valid === 1'b1) begin
                ar = !m_prio_b;
                br = m_prio_b;
            end else begin
                ar = (a_valid === 1'b1);
                br = (b_valid === 1'b1);
            end
        end
    endtask

    // Advance the model by one edge using the current inputs, then clock the DUT.
    task automatic tick();
        bit ar, br;
        logic [4:0]  rd;
        logic [31:0] d;
        model_ready(ar, br);
        if (rst_n !== 1'b1) begin
            m_prio_b = 0; m_starve = 0; m_conf = 0; m_conf4 = 0;
            m_we = 0; m_reg = '0; m_data = '0;
        end else begin
            if (ar || br) begin
                rd = ar ? a_rd : b_rd;
                d  = ar ? a_data : b_data;
                m_we   = (rd != 0);
                m_reg  = rd;
                m_data = (rd != 0) ? d : 32'd0;
            end else begin
                m_we = 0;
            end
            if (b_valid !== 1'b1 || br) m_starve = 0;
            else if (m_starve < 15) m_starve++;
            if (!m_prio_b) begin
                if (m_starve == StarveLimit) m_prio_b = 1;
            end else if (br || b_valid !== 1'b1) begin
                m_prio_b = 0;
            end
            if (a_valid === 1'b1 && b_valid === 1'b1) begin
                if (m_conf < 65535) m_conf++;
                if (m_conf4 < 15) m_conf4++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_valid = 0; b_valid = 0;
        a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] rnd_rd();
        logic [4:0] r;
        r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1; a_rd = 9; a_data = 32'hAAAA5555;
        b_valid = 1; b_rd = 10; b_data = 32'h5555AAAA;
        #1;
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
        tick();
        tick();
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
        n_checks++; if (write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_write_reg: got %0d want 0", write_reg); end
        n_checks++; if (write_data !== 32'd0) begin n_fail++; $display("FAIL reset_write_data: got %h want 0", write_data); end
        n_checks++; if (b_prio !== 1'b0) begin n_fail++; $display("FAIL reset_b_prio: got %b want 0", b_prio); end
        n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_conflict: got %0d want 0", conflict_cnt); end
        rst_n = 1'b1; a_valid = 0; b_valid = 0;
    endtask

    task automatic test_single_a();
        do_reset();
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        #1;
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_a_ready: got %b want 1", a_ready); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL single_b_ready: got %b want 0", b_ready); end
        tick();
        a_valid = 0;
        n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL single_regwrite: got %b want 1", RegWrite); end
        n_checks++; if (write_reg !== 5'd5) begin n_fail++; $display("FAIL single_write_reg: got %0d want 5", write_reg); end
        n_checks++; if (write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_write_data: got %h want deadbeef", write_data); end
        tick();
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL single_regwrite_drop: got %b want 0", RegWrite); end
        n_checks++; if (write_reg !== 5'd5) begin n_fail++; $display("FAIL single_reg_hold: got %0d want 5", write_reg); end
        n_checks++; if (write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data_hold: got %h want deadbeef", write_data); end
    endtask

    task automatic test_starve();
        do_reset();
        a_valid = 1; a_rd = 1; a_data = 32'h11;
        b_valid = 1; b_rd = 2; b_data = 32'h22;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            #1;
            n_checks++; if (a_ready !== (cyc != 5)) begin n_fail++; $display("FAIL starve_a_ready[%0d]: got %b want %b", cyc, a_ready, cyc != 5); end
            n_checks++; if (b_ready !== (cyc == 5)) begin n_fail++; $display("FAIL starve_b_ready[%0d]: got %b want %b", cyc, b_ready, cyc == 5); end
            n_checks++; if (b_prio !== (cyc == 5)) begin n_fail++; $display("FAIL starve_b_prio[%0d]: got %b want %b", cyc, b_prio, cyc == 5); end
            tick();
            n_checks++; if (write_reg !== ((cyc == 5) ? 5'd2 : 5'd1)) begin n_fail++; $display("FAIL starve_write_reg[%0d]: got %0d want %0d", cyc, write_reg, (cyc == 5) ? 2 : 1); end
        end
        n_checks++; if (conflict_cnt !== 16'd6) begin n_fail++; $display("FAIL starve_conflict: got %0d want 6", conflict_cnt); end
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_rd_zero();
        do_reset();
        a_valid = 1; a_rd = 3; a_data = 32'hCAFE0003;
        tick();
        a_valid = 0; b_valid = 1; b_rd = 0; b_data = 32'h12345678;
        #1;
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_b_ready: got %b want 1", b_ready); end
        tick();
        b_valid = 0;
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL rd0_regwrite: got %b want 0", RegWrite); end
        n_checks++; if (write_reg !== 5'd0) begin n_fail++; $display("FAIL rd0_write_reg: got %0d want 0", write_reg); end
        n_checks++; if (write_data !== 32'd0) begin n_fail++; $display("FAIL rd0_write_data: got %h want 0", write_data); end
    endtask

    task automatic test_same_rd();
        do_reset();
        a_valid = 1; a_rd = 7; a_data = 32'h1;
        b_valid = 1; b_rd = 7; b_data = 32'h2;
        tick();
        a_valid = 0;
        n_checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h1) begin
            n_fail++; $display("FAIL same_rd_first: got we=%b rd=%0d data=%h want we=1 rd=7 data=1", RegWrite, write_reg, write_data); end
        tick();
        b_valid = 0;
        n_checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h2) begin
            n_fail++; $display("FAIL same_rd_second: got we=%b rd=%0d data=%h want we=1 rd=7 data=2", RegWrite, write_reg, write_data); end
        tick();
        n_checks++; if (RegWrite !== 1'b0 || write_data !== 32'h2) begin
            n_fail++; $display("FAIL same_rd_final: got we=%b data=%h want we=0 data=2", RegWrite, write_data); end
    endtask

    task automatic test_saturate();
        do_reset();
        a_valid = 1; a_rd = 1; a_data = 32'h1;
        b_valid = 1; b_rd = 2; b_data = 32'h2;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                n_checks++; if (s_conflict_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_mid: got %0d want 14", s_conflict_cnt); end
            end
        end
        n_checks++; if (s_conflict_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt4: got %0d want 15", s_conflict_cnt); end
        n_checks++; if (conflict_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_cnt16: got %0d want 20", conflict_cnt); end
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_valid = 1; a_rd = 4; a_data = 32'hA4;
        b_valid = 1; b_rd = 6; b_data = 32'hB6;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (b_prio !== 1'b1) begin n_fail++; $display("FAIL mid_b_prio_set: got %b want 1", b_prio); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_in_reset: got a=%b b=%b want 0 0", a_ready, b_ready); end
        tick();
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL mid_regwrite: got %b want 0", RegWrite); end
        n_checks++; if (b_prio !== 1'b0) begin n_fail++; $display("FAIL mid_b_prio_clr: got %b want 0", b_prio); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL mid_a_first: got a=%b b=%b want 1 0", a_ready, b_ready); end
        tick();
        n_checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd4) begin n_fail++; $display("FAIL mid_write: got we=%b rd=%0d want we=1 rd=4", RegWrite, write_reg); end
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_random();
        bit ar, br, a_hold, b_hold;
        do_reset();
        a_hold = 0; b_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (!a_hold) begin
                a_valid = ($urandom_range(0, 2) != 0); a_rd = rnd_rd(); a_data = $urandom;
            end
            if (!b_hold) begin
                b_valid = ($urandom_range(0, 3) != 0); b_rd = rnd_rd(); b_data = $urandom;
            end
            #1;
            model_ready(ar, br);
            n_checks++; if (a_ready !== ar || b_ready !== br) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got a=%b b=%b want a=%b b=%b", i, a_ready, b_ready, ar, br); end
            a_hold = a_valid && !ar;
            b_hold = b_valid && !br;
            tick();
            n_checks++; if (RegWrite !== m_we || write_reg !== m_reg || write_data !== m_data) begin
                n_fail++; $display("FAIL rand_write[%0d]: got we=%b rd=%0d data=%h want we=%b rd=%0d data=%h",
                                   i, RegWrite, write_reg, write_data, m_we, m_reg, m_data); end
            n_checks++; if (b_prio !== m_prio_b) begin n_fail++; $display("FAIL rand_b_prio[%0d]: got %b want %b", i, b_prio, m_prio_b); end
            n_checks++; if (conflict_cnt !== 16'(m_conf) || s_conflict_cnt !== 4'(m_conf4)) begin
                n_fail++; $display("FAIL rand_conflict[%0d]: got %0d/%0d want %0d/%0d", i, conflict_cnt, s_conflict_cnt, m_conf, m_conf4); end
        end
        rst_n = 1'b1; a_valid = 0; b_valid = 0;
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 0; b_valid = 0;
        a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
        #2;
        test_reset();
        test_single_a();
        test_starve();
        test_rd_zero();
        test_same_rd();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
